// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bus of the sequential ALU.
//   master : drives IN_VALID, DATA1, DATA2, SELECT, OUT_READY (register-file side/consumer)
//   slave  : drives IN_READY, OUT_VALID, RESULT, ZERO, CARRY, ILLEGAL (the ALU)
interface alu_seq_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [2:0]       SELECT;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             CARRY;
    logic             ILLEGAL;

    modport master (
        output IN_VALID, DATA1, DATA2, SELECT, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, ZERO, CARRY, ILLEGAL
    );

    modport slave (
        input  IN_VALID, DATA1, DATA2, SELECT, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, ZERO, CARRY, ILLEGAL
    );
endinterface

// File: rtl/alu_iter_shifter.sv
// Iterative one-bit-per-cycle shifter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture operand_i, shamt_i and direction left_i
//   step_i       : perform one shift step if any remain
//   result_o     : value after the step that would happen this cycle (data itself if count 0)
//   carry_o      : bit shifted out by that step (last bit out, 0 if never shifted)
//   done_o       : at most one step remains, so result_o/carry_o are final
module alu_iter_shifter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               left_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               step_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               carry_o,
    output logic               done_o
);
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic               last_q;

    logic [WIDTH-1:0]   shifted;
    logic               out_bit;

    always_comb begin
        shifted = '0;
        out_bit = 1'b0;
        if (left_q) begin
            shifted = {data_q[WIDTH-2:0], 1'b0};
            out_bit = data_q[WIDTH-1];
        end else begin
            shifted = {1'b0, data_q[WIDTH-1:1]};
            out_bit = data_q[0];
        end
    end

    // Exposing the post-step value lets the caller capture the final result on the
    // same edge as the last step, so a shift by N takes exactly N cycles.
    assign result_o = (cnt_q == '0) ? data_q : shifted;
    assign carry_o  = (cnt_q == '0) ? last_q : out_bit;
    assign done_o   = (cnt_q <= SHAMT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            last_q <= 1'b0;
        end else if (load_i) begin
            data_q <= operand_i;
            cnt_q  <= shamt_i;
            left_q <= left_i;
            last_q <= 1'b0;
        end else if (step_i && (cnt_q != '0)) begin
            data_q <= shifted;
            cnt_q  <= cnt_q - SHAMT_W'(1);
            last_q <= out_bit;
        end
    end
endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked multi-cycle ALU: FORWARD/ADD/AND/OR/SUB/SLL/SRL with ZERO/CARRY/ILLEGAL.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : alu_seq_unit_if slave
//                IN_VALID/IN_READY accept DATA1, DATA2, SELECT (IN_READY = IDLE)
//                OUT_VALID/OUT_READY return RESULT, ZERO, CARRY, ILLEGAL (held in DONE)
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    alu_seq_unit_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             illegal_q;
    logic             out_valid_q;

    logic             accept;
    logic             exec_done;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             carry_d;
    logic             illegal_d;

    logic [WIDTH-1:0] sh_result;
    logic             sh_carry;
    logic             sh_done;

    assign accept = bus.IN_VALID && (state_q == ST_IDLE);

    // The shifter snoops the bus directly so it is loaded on the accept edge itself.
    alu_iter_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .load_i    (accept),
        .left_i    (bus.SELECT == OP_SLL),
        .operand_i (bus.DATA1),
        .shamt_i   (bus.DATA2[SHAMT_W-1:0]),
        .step_i    (state_q == ST_EXEC),
        .result_o  (sh_result),
        .carry_o   (sh_carry),
        .done_o    (sh_done)
    );

    // Subtraction as A + ~B + 1 makes the top bit a "no borrow" flag.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

    always_comb begin
        result_d  = '0;
        carry_d   = 1'b0;
        illegal_d = 1'b0;
        case (op_q)
            OP_FWD:  result_d = b_q;
            OP_ADD:  {carry_d, result_d} = sum;
            OP_AND:  result_d = a_q & b_q;
            OP_OR:   result_d = a_q | b_q;
            OP_SUB:  {carry_d, result_d} = diff;
            OP_SLL,
            OP_SRL: begin
                result_d = sh_result;
                carry_d  = sh_carry;
            end
            default: illegal_d = 1'b1;
        endcase
        zero_d = (result_d == '0);
    end

    always_comb begin
        case (op_q)
            OP_ADD, OP_SUB: exec_done = (cnt_q == '0);
            OP_SLL, OP_SRL: exec_done = sh_done;
            default:        exec_done = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_FWD;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.IN_VALID) begin
                        op_q    <= bus.SELECT;
                        a_q     <= bus.DATA1;
                        b_q     <= bus.DATA2;
                        cnt_q   <= CNT_W'(ADD_LAT - 1);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        result_q    <= result_d;
                        zero_q      <= zero_d;
                        carry_q     <= carry_d;
                        illegal_q   <= illegal_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = (state_q == ST_IDLE);
    assign bus.OUT_VALID = out_valid_q;
    assign bus.RESULT    = result_q;
    assign bus.ZERO      = zero_q;
    assign bus.CARRY     = carry_q;
    assign bus.ILLEGAL   = illegal_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: an 8-bit (ADD_LAT=2) and a 16-bit (ADD_LAT=3) instance driven
// with directed and random operations, checked against an arithmetic reference model.
module tb_alu_seq_unit;
    import alu_pkg::*;

    localparam int unsigned LAT8  = 2;
    localparam int unsigned LAT16 = 3;

    typedef struct packed {
        logic        rdy;
        logic        ov;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        il;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(8))  bus8 ();
    alu_seq_unit_if #(.WIDTH(16)) bus16 ();

    alu_seq_unit #(.WIDTH(8), .ADD_LAT(LAT8)) u_dut8 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus8.slave)
    );

    alu_seq_unit #(.WIDTH(16), .ADD_LAT(LAT16)) u_dut16 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus16.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_in(input int w, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] op);
        if (w == 8) begin
            bus8.IN_VALID = v;
            bus8.DATA1    = a[7:0];
            bus8.DATA2    = b[7:0];
            bus8.SELECT   = op;
        end else begin
            bus16.IN_VALID = v;
            bus16.DATA1    = a;
            bus16.DATA2    = b;
            bus16.SELECT   = op;
        end
    endtask

    task automatic set_out_ready(input int w, input logic r);
        if (w == 8) bus8.OUT_READY = r;
        else        bus16.OUT_READY = r;
    endtask

    function automatic obs_t observe(input int w);
        obs_t o;
        if (w == 8) begin
            o.rdy = bus8.IN_READY;  o.ov = bus8.OUT_VALID; o.res = {8'h00, bus8.RESULT};
            o.z   = bus8.ZERO;      o.c  = bus8.CARRY;     o.il  = bus8.ILLEGAL;
        end else begin
            o.rdy = bus16.IN_READY; o.ov = bus16.OUT_VALID; o.res = bus16.RESULT;
            o.z   = bus16.ZERO;     o.c  = bus16.CARRY;     o.il  = bus16.ILLEGAL;
        end
        return o;
    endfunction

    // Reference: plain unsigned arithmetic on integers, independent of any bit-serial view.
    task automatic model(input int w, input int unsigned a, input int unsigned b,
                         input logic [2:0] op, output int unsigned res,
                         output int unsigned c, output int unsigned il,
                         output int unsigned cyc);
        int unsigned mask = (w == 8) ? 32'hFF : 32'hFFFF;
        int unsigned lat  = (w == 8) ? LAT8 : LAT16;
        int unsigned sh   = b % ((w == 8) ? 8 : 16);
        res = 0; c = 0; il = 0; cyc = 1;
        case (op)
            OP_FWD: res = b;
            OP_ADD: begin res = (a + b) & mask; c = ((a + b) > mask); cyc = lat; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SUB: begin res = (a - b) & mask; c = (a >= b); cyc = lat; end
            OP_SLL: begin
                res = (a << sh) & mask;
                c   = (sh == 0) ? 0 : ((a >> (w - sh)) & 1);
                cyc = (sh == 0) ? 1 : sh;
            end
            OP_SRL: begin
                res = a >> sh;
                c   = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1);
                cyc = (sh == 0) ? 1 : sh;
            end
            default: il = 1;
        endcase
    endtask

    // Called a little after a rising edge; returns a little after the accept edge.
    task automatic start_op(input int w, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b);
        obs_t o = observe(w);
        check_eq($sformatf("w%0d ready_before_accept", w), o.rdy, 1);
        drive_in(w, 1'b1, a, b, op);
        @(posedge clk);
        #1;
        // Garbage on the inputs while busy must not leak into the operation.
        drive_in(w, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
    endtask

    task automatic run_op(input int w, input logic [2:0] op, input int unsigned a_in,
                          input int unsigned b_in, input int bp);
        int unsigned mask = (w == 8) ? 32'hFF : 32'hFFFF;
        int unsigned a = a_in & mask;
        int unsigned b = b_in & mask;
        int unsigned res, c, il, cyc;
        int   n = 0;
        logic got = 1'b0;
        obs_t o, e;
        string tag = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, a, b);

        model(w, a, b, op, res, c, il, cyc);
        e.rdy = 1'b0; e.ov = 1'b1; e.res = 16'(res);
        e.z = (res == 0); e.c = c[0]; e.il = il[0];

        start_op(w, op, 16'(a), 16'(b));
        while (n < 64 && !got) begin
            @(posedge clk);
            #1;
            n++;
            o = observe(w);
            got = o.ov;
        end
        if (!got) begin
            check_eq({tag, " out_valid_timeout"}, 0, 1);
            return;
        end
        check_eq({tag, " latency"}, n, cyc);
        o = observe(w);
        check_eq({tag, " result"},  o.res, e.res);
        check_eq({tag, " zero"},    o.z, e.z);
        check_eq({tag, " carry"},   o.c, e.c);
        check_eq({tag, " illegal"}, o.il, e.il);
        check_eq({tag, " ready_in_done"}, o.rdy, 0);

        for (int i = 0; i < bp; i++) begin
            drive_in(w, 1'b1, 16'($urandom), 16'($urandom), 3'($urandom));
            @(posedge clk);
            #1;
            check_eq({tag, " backpressure_hold"}, observe(w), e);
        end

        drive_in(w, 1'b0, 16'h0, 16'h0, OP_FWD);
        set_out_ready(w, 1'b1);
        @(posedge clk);
        #1;
        set_out_ready(w, 1'b0);
        e.rdy = 1'b1; e.ov = 1'b0;
        check_eq({tag, " after_consume"}, observe(w), e);
    endtask

    initial begin
        obs_t e;
        rst = 1'b1;
        drive_in(8, 1'b0, 16'h0, 16'h0, OP_FWD);
        drive_in(16, 1'b0, 16'h0, 16'h0, OP_FWD);
        set_out_ready(8, 1'b0);
        set_out_ready(16, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        e = '0;
        e.rdy = 1'b1;
        check_eq("w8 reset_state", observe(8), e);
        check_eq("w16 reset_state", observe(16), e);

        for (int k = 0; k < 2; k++) begin
            int w = (k == 0) ? 8 : 16;
            run_op(w, OP_ADD, 'hF0, 'h20, 0);
            run_op(w, OP_ADD, 'hFFF0, 'h0020, 0);
            run_op(w, OP_SUB, 'h05, 'h07, 0);
            run_op(w, OP_SUB, 'h07, 'h07, 1);
            run_op(w, OP_SLL, 'h81, 3, 0);
            run_op(w, OP_SRL, 'h81, 1, 0);
            run_op(w, OP_SLL, 'h81, 0, 0);
            run_op(w, OP_SRL, 'h8001, 15, 0);
            run_op(w, OP_FWD, 'h12, 'hA5, 0);
            run_op(w, OP_AND, 'hCC, 'hAA, 0);
            run_op(w, OP_OR,  'h0C, 'hA0, 0);
            run_op(w, OP_RSVD, 'hFFFF, 'h33, 0);
            run_op(w, OP_ADD, 'h3C, 'h41, 5);
        end

        // Reset mid-operation: leave a nonzero result/carry, then kill an SLL by 7.
        run_op(8, OP_ADD, 'hF0, 'h20, 0);
        start_op(8, OP_SLL, 16'h0081, 16'h0007);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = '0;
        e.rdy = 1'b1;
        check_eq("w8 reset_mid_op", observe(8), e);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("w8 no_result_after_reset", observe(8), e);
        end

        for (int i = 0; i < 40; i++) begin
            run_op(8, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
            run_op(16, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
